// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and constants for the DDR command arbiter
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_ARB       = 2'd1,
    ST_CMD       = 2'd2,
    ST_WDATA     = 2'd3
  } arb_state_t;

  localparam logic REQ_W = 1'b0;
  localparam logic REQ_R = 1'b1;

  localparam int RD_OS_CNT_W = 4;

endpackage

// File: rtl/ddr_rr_arb2.sv
// rtl/ddr_rr_arb2.sv - two-way round-robin grant, pointer moves away from each winner
module ddr_rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic grant_w,
  output logic grant_r
);

  logic ptr;

  // Pointer only breaks ties; a lone requester always wins
  always_comb begin
    grant_w = en && req_w && (!req_r || (ptr == REQ_W));
    grant_r = en && req_r && (!req_w || (ptr == REQ_R));
  end

  // After any grant the other requester gets priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_W;
    end else if (grant_w) begin
      ptr <= REQ_R;
    end else if (grant_r) begin
      ptr <= REQ_W;
    end
  end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// rtl/ddr_cmd_arbiter.sv - shares the DDR user command/write-data port between DMA write and read engines
module ddr_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_RD_OS = 4
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic                   ddr_init_done,
  input  logic                   w_cmd_valid,
  output logic                   w_cmd_ready,
  input  logic [ADDR_W-1:0]      w_cmd_addr,
  input  logic [LEN_W-1:0]       w_cmd_len,
  input  logic                   w_dat_valid,
  output logic                   w_dat_ready,
  input  logic [DATA_W-1:0]      w_dat,
  input  logic                   r_cmd_valid,
  output logic                   r_cmd_ready,
  input  logic [ADDR_W-1:0]      r_cmd_addr,
  input  logic [LEN_W-1:0]       r_cmd_len,
  output logic                   m_cmd_valid,
  input  logic                   m_cmd_ready,
  output logic                   m_cmd_wr,
  output logic [ADDR_W-1:0]      m_cmd_addr,
  output logic [LEN_W-1:0]       m_cmd_len,
  output logic                   m_wdat_valid,
  input  logic                   m_wdat_ready,
  output logic [DATA_W-1:0]      m_wdat,
  output logic                   m_wdat_last,
  input  logic                   m_rlast_valid,
  output logic [RD_OS_CNT_W-1:0] rd_os_cnt
);

  arb_state_t       state, state_nxt;
  logic             arb_en, grant_w, grant_r;
  logic             elig_w, elig_r;
  logic             cmd_hs, beat_hs, rd_inc, rd_dec;
  logic [LEN_W-1:0] beat_cnt;

  assign elig_w  = w_cmd_valid;
  assign elig_r  = r_cmd_valid && (rd_os_cnt < RD_OS_CNT_W'(MAX_RD_OS));
  assign cmd_hs  = m_cmd_valid && m_cmd_ready;
  assign beat_hs = (state == ST_WDATA) && w_dat_valid && m_wdat_ready;
  assign rd_inc  = cmd_hs && !m_cmd_wr;
  assign rd_dec  = m_rlast_valid && (rd_os_cnt != '0);

  // Data bus follows the writer; only the valid/ready gating depends on state
  assign m_wdat = w_dat;

  ddr_rr_arb2 u_rr (
    .clk     (core_clk),
    .rst     (core_rst),
    .en      (arb_en),
    .req_w   (elig_w),
    .req_r   (elig_r),
    .grant_w (grant_w),
    .grant_r (grant_r)
  );

  // State register
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state <= ST_WAIT_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the state-decoded handshakes and write-beat forwarding
  always_comb begin
    state_nxt    = state;
    arb_en       = 1'b0;
    w_cmd_ready  = 1'b0;
    r_cmd_ready  = 1'b0;
    m_wdat_valid = 1'b0;
    w_dat_ready  = 1'b0;
    m_wdat_last  = 1'b0;
    case (state)
      ST_WAIT_INIT: begin
        if (ddr_init_done) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        arb_en      = 1'b1;
        w_cmd_ready = grant_w;
        r_cmd_ready = grant_r;
        if (grant_w || grant_r) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (m_cmd_ready) state_nxt = m_cmd_wr ? ST_WDATA : ST_ARB;
      end
      ST_WDATA: begin
        m_wdat_valid = w_dat_valid;
        w_dat_ready  = m_wdat_ready;
        m_wdat_last  = (beat_cnt == '0);
        if (beat_hs && (beat_cnt == '0)) state_nxt = ST_ARB;
      end
      default: state_nxt = ST_WAIT_INIT;
    endcase
  end

  // Registered command slot, write beat countdown and outstanding-read count
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      m_cmd_valid <= 1'b0;
      m_cmd_wr    <= 1'b0;
      m_cmd_addr  <= '0;
      m_cmd_len   <= '0;
      beat_cnt    <= '0;
      rd_os_cnt   <= '0;
    end else begin
      if (grant_w) begin
        m_cmd_valid <= 1'b1;
        m_cmd_wr    <= 1'b1;
        m_cmd_addr  <= w_cmd_addr;
        m_cmd_len   <= w_cmd_len;
      end else if (grant_r) begin
        m_cmd_valid <= 1'b1;
        m_cmd_wr    <= 1'b0;
        m_cmd_addr  <= r_cmd_addr;
        m_cmd_len   <= r_cmd_len;
      end else if (cmd_hs) begin
        m_cmd_valid <= 1'b0;
      end

      if (cmd_hs && m_cmd_wr) begin
        beat_cnt <= m_cmd_len;
      end else if (beat_hs) begin
        beat_cnt <= beat_cnt - LEN_W'(1);
      end

      case ({rd_inc, rd_dec})
        2'b10:   rd_os_cnt <= rd_os_cnt + RD_OS_CNT_W'(1);
        2'b01:   rd_os_cnt <= rd_os_cnt - RD_OS_CNT_W'(1);
        default: rd_os_cnt <= rd_os_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb/tb_ddr_cmd_arbiter.sv - self-checking bench for ddr_cmd_arbiter
module tb_ddr_cmd_arbiter;

  logic         core_clk = 1'b0;
  logic         core_rst, ddr_init_done;
  logic         w_cmd_valid, w_cmd_ready, w_dat_valid, w_dat_ready;
  logic [27:0]  w_cmd_addr, r_cmd_addr, m_cmd_addr;
  logic [3:0]   w_cmd_len, r_cmd_len, m_cmd_len, rd_os_cnt;
  logic [127:0] w_dat, m_wdat;
  logic         r_cmd_valid, r_cmd_ready;
  logic         m_cmd_valid, m_cmd_ready, m_cmd_wr;
  logic         m_wdat_valid, m_wdat_ready, m_wdat_last, m_rlast_valid;

  int n_chk = 0, n_fail = 0;
  int n_rd, n_wr, n_beat;

  always #5 core_clk = ~core_clk;

  ddr_cmd_arbiter dut (
    .core_clk(core_clk), .core_rst(core_rst), .ddr_init_done(ddr_init_done),
    .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready), .w_cmd_addr(w_cmd_addr),
    .w_cmd_len(w_cmd_len), .w_dat_valid(w_dat_valid), .w_dat_ready(w_dat_ready),
    .w_dat(w_dat), .r_cmd_valid(r_cmd_valid), .r_cmd_ready(r_cmd_ready),
    .r_cmd_addr(r_cmd_addr), .r_cmd_len(r_cmd_len), .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready), .m_cmd_wr(m_cmd_wr), .m_cmd_addr(m_cmd_addr),
    .m_cmd_len(m_cmd_len), .m_wdat_valid(m_wdat_valid), .m_wdat_ready(m_wdat_ready),
    .m_wdat(m_wdat), .m_wdat_last(m_wdat_last), .m_rlast_valid(m_rlast_valid),
    .rd_os_cnt(rd_os_cnt)
  );

  typedef struct {
    logic        wr;
    logic [27:0] addr;
    logic [3:0]  len;
  } cmd_t;

  // in  = {init, w_cmd_valid, r_cmd_valid, m_cmd_ready, w_dat_valid, m_wdat_ready, m_rlast_valid}
  // ctl = {w_cmd_ready, r_cmd_ready, m_cmd_valid, m_cmd_wr}; wd = {w_dat_ready, m_wdat_valid, m_wdat_last}
  typedef struct packed {
    logic [6:0]  in;
    logic [3:0]  ctl;
    logic [11:0] addr;
    logic [2:0]  wd;
    logic [3:0]  os;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge core_clk);
    #1;
  endtask

  task automatic clr_in();
    ddr_init_done = 1'b0; w_cmd_valid = 1'b0; r_cmd_valid = 1'b0;
    w_cmd_addr = '0; r_cmd_addr = '0; w_cmd_len = '0; r_cmd_len = '0;
    w_dat_valid = 1'b0; w_dat = '0; m_cmd_ready = 1'b0; m_wdat_ready = 1'b0;
    m_rlast_valid = 1'b0;
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_w_cmd_ready"}, w_cmd_ready, 0);
    chk({tag, "_r_cmd_ready"}, r_cmd_ready, 0);
    chk({tag, "_w_dat_ready"}, w_dat_ready, 0);
    chk({tag, "_m_cmd_valid"}, m_cmd_valid, 0);
    chk({tag, "_m_cmd_wr"}, m_cmd_wr, 0);
    chk({tag, "_m_cmd_addr"}, m_cmd_addr, 0);
    chk({tag, "_m_cmd_len"}, m_cmd_len, 0);
    chk({tag, "_m_wdat_valid"}, m_wdat_valid, 0);
    chk({tag, "_m_wdat_last"}, m_wdat_last, 0);
    chk({tag, "_rd_os_cnt"}, rd_os_cnt, 0);
  endtask

  task automatic do_reset();
    clr_in();
    n_rd = 0; n_wr = 0; n_beat = 0;
    core_rst = 1'b1;
    cyc(); cyc();
    core_rst = 1'b0;
    @(negedge core_clk);
    chk_rst("rst");
    cyc();
  endtask

  // Advance n cycles, counting downstream handshakes seen before each edge
  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge core_clk);
      if (m_cmd_valid && m_cmd_ready) begin
        if (m_cmd_wr) n_wr++; else n_rd++;
      end
      if (m_wdat_valid && m_wdat_ready) n_beat++;
      cyc();
    end
  endtask

  initial begin
    int   beats, got, src, bl, os, inc;
    int   wrseq[$];
    cmd_t pend[$];
    cmd_t c;
    bit   live, turn_r, ok, ew, er, gw, gr, strm;

    core_rst = 1'b1;
    vecs[0]  = '{7'b1110000, 4'b0000, 12'h000, 3'b000, 4'd0};
    vecs[1]  = '{7'b1110000, 4'b1000, 12'h000, 3'b000, 4'd0};
    vecs[2]  = '{7'b1010000, 4'b0011, 12'h123, 3'b000, 4'd0};
    vecs[3]  = '{7'b1011000, 4'b0011, 12'h123, 3'b000, 4'd0};
    vecs[4]  = '{7'b1010110, 4'b0001, 12'h123, 3'b110, 4'd0};
    vecs[5]  = '{7'b1010110, 4'b0001, 12'h123, 3'b111, 4'd0};
    vecs[6]  = '{7'b0110110, 4'b0101, 12'h123, 3'b000, 4'd0};
    vecs[7]  = '{7'b0101000, 4'b0010, 12'h456, 3'b000, 4'd0};
    vecs[8]  = '{7'b0100000, 4'b1000, 12'h456, 3'b000, 4'd1};
    vecs[9]  = '{7'b0010001, 4'b0011, 12'h123, 3'b000, 4'd1};
    vecs[10] = '{7'b0010000, 4'b0011, 12'h123, 3'b000, 4'd0};

    // Init hold, then table-driven first grants
    do_reset();
    w_cmd_valid = 1'b1; r_cmd_valid = 1'b1;
    w_cmd_addr = 28'h123; r_cmd_addr = 28'h456; w_cmd_len = 4'd1; r_cmd_len = 4'd2;
    w_dat = 128'hdead;
    for (int k = 0; k < 50; k++) begin
      @(negedge core_clk);
      chk("hold_w_cmd_ready", w_cmd_ready, 0);
      chk("hold_r_cmd_ready", r_cmd_ready, 0);
      chk("hold_m_cmd_valid", m_cmd_valid, 0);
      cyc();
    end
    for (int i = 0; i < 11; i++) begin
      {ddr_init_done, w_cmd_valid, r_cmd_valid, m_cmd_ready, w_dat_valid,
       m_wdat_ready, m_rlast_valid} = vecs[i].in;
      @(negedge core_clk);
      chk($sformatf("vec%0d_ctl", i), {w_cmd_ready, r_cmd_ready, m_cmd_valid, m_cmd_wr}, vecs[i].ctl);
      chk($sformatf("vec%0d_addr", i), m_cmd_addr, vecs[i].addr);
      chk($sformatf("vec%0d_wd", i), {w_dat_ready, m_wdat_valid, m_wdat_last}, vecs[i].wd);
      chk($sformatf("vec%0d_os", i), rd_os_cnt, vecs[i].os);
      if (vecs[i].wd[1]) chk($sformatf("vec%0d_wdat", i), m_wdat, 128'hdead);
      cyc();
    end

    // Fairness: alternating W/R, each write exactly four beats
    do_reset();
    ddr_init_done = 1'b1; w_cmd_valid = 1'b1; r_cmd_valid = 1'b1;
    w_cmd_len = 4'd3; m_cmd_ready = 1'b1; m_wdat_ready = 1'b1; w_dat_valid = 1'b1;
    beats = 0;
    wrseq.delete();
    for (int k = 0; k < 300 && wrseq.size() < 6; k++) begin
      @(negedge core_clk);
      if (m_cmd_valid && m_cmd_ready) wrseq.push_back(int'(m_cmd_wr));
      if (m_wdat_valid && m_wdat_ready) begin
        beats++;
        if (m_wdat_last) begin
          chk("fair_beats", beats, 4);
          beats = 0;
        end
      end
      cyc();
    end
    chk("fair_count", wrseq.size(), 6);
    for (int k = 0; k < wrseq.size(); k++) chk("fair_order", wrseq[k], (k % 2 == 0) ? 1 : 0);

    // Backpressure on command and on write beats
    do_reset();
    ddr_init_done = 1'b1; w_cmd_valid = 1'b1; w_cmd_addr = 28'hABCDE0; w_cmd_len = 4'd15;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge core_clk);
      ok = w_cmd_ready;
      cyc();
    end
    chk("bp_grant", ok, 1);
    w_cmd_valid = 1'b0; w_cmd_addr = 28'h5555555; w_cmd_len = 4'd2;
    for (int k = 0; k < 10; k++) begin
      @(negedge core_clk);
      chk("bp_hold_valid", m_cmd_valid, 1);
      chk("bp_hold_addr", m_cmd_addr, 28'hABCDE0);
      chk("bp_hold_len", m_cmd_len, 15);
      chk("bp_hold_wr", m_cmd_wr, 1);
      cyc();
    end
    m_cmd_ready = 1'b1;
    cyc();
    m_cmd_ready = 1'b0;
    got = 0; src = 0; w_dat_valid = 1'b1;
    for (int k = 0; k < 100 && got < 16; k++) begin
      m_wdat_ready = (k % 2 == 1);
      w_dat = 128'(src);
      @(negedge core_clk);
      if (m_wdat_valid && m_wdat_ready) begin
        chk("bp_data", m_wdat, got);
        chk("bp_last", m_wdat_last, got == 15);
        got++;
      end
      if (w_dat_valid && w_dat_ready) src++;
      cyc();
    end
    chk("bp_beats", got, 16);

    // Read cap: four issued, write still wins, one return frees a slot
    do_reset();
    ddr_init_done = 1'b1; r_cmd_valid = 1'b1; r_cmd_len = 4'd7; r_cmd_addr = 28'h40;
    m_cmd_ready = 1'b1;
    run(40);
    chk("rcap_reads", n_rd, 4);
    chk("rcap_cnt", rd_os_cnt, 4);
    w_cmd_valid = 1'b1; w_cmd_len = 4'd0; w_dat_valid = 1'b1; m_wdat_ready = 1'b1;
    run(3);
    w_cmd_valid = 1'b0;
    run(6);
    chk("rcap_w_wins", n_wr, 1);
    chk("rcap_r_stalled", n_rd, 4);
    m_rlast_valid = 1'b1;
    run(1);
    m_rlast_valid = 1'b0;
    run(10);
    chk("rcap_fifth", n_rd, 5);
    chk("rcap_cnt2", rd_os_cnt, 4);

    // Read issue coinciding with a read return leaves the count unchanged
    do_reset();
    ddr_init_done = 1'b1; r_cmd_valid = 1'b1; m_cmd_ready = 1'b1;
    for (int k = 0; k < 20 && n_rd < 2; k++) run(1);
    m_cmd_ready = 1'b0;
    run(3);
    chk("sim_pre_cnt", rd_os_cnt, 2);
    chk("sim_pre_valid", m_cmd_valid, 1);
    m_cmd_ready = 1'b1; m_rlast_valid = 1'b1;
    run(1);
    m_cmd_ready = 1'b0; m_rlast_valid = 1'b0; r_cmd_valid = 1'b0;
    @(negedge core_clk);
    chk("sim_cnt", rd_os_cnt, 2);
    chk("sim_issued", n_rd, 3);
    cyc();

    // Spurious read return at zero
    do_reset();
    ddr_init_done = 1'b1; m_rlast_valid = 1'b1;
    run(3);
    m_rlast_valid = 1'b0;
    @(negedge core_clk);
    chk("spur_cnt", rd_os_cnt, 0);
    cyc();

    // Reset during beat 2 of an eight-beat write
    do_reset();
    ddr_init_done = 1'b1; r_cmd_valid = 1'b1; m_cmd_ready = 1'b1;
    for (int k = 0; k < 10 && n_rd < 1; k++) run(1);
    r_cmd_valid = 1'b0; w_cmd_valid = 1'b1; w_cmd_len = 4'd7;
    for (int k = 0; k < 10 && n_wr < 1; k++) run(1);
    w_cmd_valid = 1'b0; w_dat_valid = 1'b1; m_wdat_ready = 1'b1;
    for (int k = 0; k < 10 && n_beat < 1; k++) run(1);
    chk("mid_beat1", n_beat, 1);
    chk("mid_pre_os", rd_os_cnt, 1);
    core_rst = 1'b1; w_cmd_valid = 1'b1; r_cmd_valid = 1'b1;
    cyc();
    core_rst = 1'b0;
    @(negedge core_clk);
    chk_rst("mid");
    cyc();

    // Randomized traffic against a transaction-level reference
    do_reset();
    live = 0; turn_r = 0; bl = -1; os = 0;
    pend.delete();
    for (int k = 0; k < 3000; k++) begin
      ddr_init_done = (k < 15) ? 1'b0 : ($urandom_range(0, 39) != 0);
      w_cmd_valid   = ($urandom_range(0, 2) != 0);
      r_cmd_valid   = ($urandom_range(0, 2) != 0);
      w_cmd_addr    = 28'($urandom);
      r_cmd_addr    = 28'($urandom);
      w_cmd_len     = 4'($urandom_range(0, 15));
      r_cmd_len     = 4'($urandom_range(0, 15));
      m_cmd_ready   = ($urandom_range(0, 3) != 0);
      m_wdat_ready  = ($urandom_range(0, 3) != 0);
      w_dat_valid   = ($urandom_range(0, 3) != 0);
      m_rlast_valid = ($urandom_range(0, 4) == 0);
      w_dat         = {$urandom, $urandom, $urandom, $urandom};
      @(negedge core_clk);
      ok = live && pend.size() == 0 && bl < 0;
      ew = w_cmd_valid;
      er = r_cmd_valid && os < 4;
      gw = ok && ew && (!er || !turn_r);
      gr = ok && er && (!ew || turn_r);
      strm = bl >= 0;
      chk("rnd_w_cmd_ready", w_cmd_ready, gw);
      chk("rnd_r_cmd_ready", r_cmd_ready, gr);
      chk("rnd_m_cmd_valid", m_cmd_valid, pend.size() > 0);
      if (pend.size() > 0) begin
        chk("rnd_m_cmd_wr", m_cmd_wr, pend[0].wr);
        chk("rnd_m_cmd_addr", m_cmd_addr, pend[0].addr);
        chk("rnd_m_cmd_len", m_cmd_len, pend[0].len);
      end
      chk("rnd_m_wdat_valid", m_wdat_valid, strm && w_dat_valid);
      chk("rnd_w_dat_ready", w_dat_ready, strm && m_wdat_ready);
      chk("rnd_m_wdat_last", m_wdat_last, strm && bl == 0);
      if (strm && w_dat_valid) chk("rnd_m_wdat", m_wdat, w_dat);
      chk("rnd_rd_os_cnt", rd_os_cnt, os);
      inc = 0;
      if (strm && w_dat_valid && m_wdat_ready) bl--;
      if (pend.size() > 0 && m_cmd_ready) begin
        c = pend.pop_front();
        if (c.wr) bl = int'(c.len); else inc = 1;
      end
      os = os + inc - ((m_rlast_valid && os > 0) ? 1 : 0);
      if (gw) begin
        c.wr = 1'b1; c.addr = w_cmd_addr; c.len = w_cmd_len;
        pend.push_back(c);
        turn_r = 1;
      end
      if (gr) begin
        c.wr = 1'b0; c.addr = r_cmd_addr; c.len = r_cmd_len;
        pend.push_back(c);
        turn_r = 0;
      end
      if (ddr_init_done) live = 1;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
